stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_rr.sv | 156 +++++++++++++++
 tb/tb_stream_mux_rr.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// Registered N-channel stream multiplexer with valid/ready handshakes on
// every input and on the output. Each transfer takes one channel, picked
// either by an explicit select code (fixed mode) or by round-robin
// arbitration over the requesting channels. The chosen data sits in a
// single output register stage.
//
// Parameters:
//   WIDTH    - data width per channel
//   CHANNELS - number of input channels (>= 2, any count)
//   SEL_W    - derived width of the select / channel-tag fields
//
// Ports:
//   clk       - clock, rising edge
//   reset     - asynchronous, active-high reset
//   in_data   - flattened inputs, channel i at [i*WIDTH +: WIDTH]
//   in_valid  - per-channel valid
//   in_ready  - per-channel ready, at most one bit high
//   mode      - 0 = fixed select, 1 = round-robin
//   sel       - channel index used in fixed mode
//   out_data  - registered selected data
//   out_chan  - index of the channel that supplied out_data
//   out_valid - output register holds data
//   out_ready - consumer accepts out_data this cycle
module stream_mux_rr #(
  parameter  int WIDTH    = 16,
  parameter  int CHANNELS = 8,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Every SEL_W-bit code has a slot here; codes beyond the last real
  // channel read as "not valid", so an out-of-range sel simply never grants.
  localparam int PAD = 1 << SEL_W;

  logic [WIDTH-1:0]    out_data_reg, out_data_next;
  logic [SEL_W-1:0]    out_chan_reg, out_chan_next;
  logic                out_valid_reg, out_valid_next;
  logic [SEL_W-1:0]    ptr_reg, ptr_next;

  logic [PAD-1:0]      valid_pad;
  logic [WIDTH-1:0]    chan_data [CHANNELS];
  logic [CHANNELS-1:0] rr_mask;
  logic [CHANNELS-1:0] rr_hi;
  logic                grant_any;
  logic [SEL_W-1:0]    grant_idx;
  logic [WIDTH-1:0]    sel_data;
  logic                can_load;
  logic                load;

  // Index of the lowest set bit; zero when the vector is empty (callers
  // only use the result when some bit is set).
  function automatic logic [SEL_W-1:0] lowest_idx(input logic [CHANNELS-1:0] v);
    lowest_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = SEL_W'(i);
    end
  endfunction

  generate
    for (genvar gi = 0; gi < PAD; gi++) begin : g_pad
      if (gi < CHANNELS) begin : g_real
        assign valid_pad[gi] = in_valid[gi];
      end else begin : g_none
        assign valid_pad[gi] = 1'b0;
      end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Channels at or above the pointer get first pick; if none of them is
  // requesting, the scan wraps around to the lowest requester overall.
  assign rr_mask = {CHANNELS{1'b1}} << ptr_reg;
  assign rr_hi   = in_valid & rr_mask;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    if (mode) begin
      grant_any = |in_valid;
      grant_idx = (|rr_hi) ? lowest_idx(rr_hi) : lowest_idx(in_valid);
    end else begin
      grant_any = valid_pad[sel];
      grant_idx = sel;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_idx == SEL_W'(i)) sel_data = chan_data[i];
    end
  end

  assign can_load = !out_valid_reg || out_ready;
  assign load     = grant_any && can_load;

  // Ready is forced low while reset is held so no producer sees a
  // handshake that the cleared register would then lose.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ready
      assign in_ready[gi] = load && !reset && (grant_idx == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    out_data_next  = out_data_reg;
    out_chan_next  = out_chan_reg;
    out_valid_next = out_valid_reg;
    ptr_next       = ptr_reg;
    if (load) begin
      out_data_next  = sel_data;
      out_chan_next  = grant_idx;
      out_valid_next = 1'b1;
      // Only round-robin transfers move the pointer past the winner.
      if (mode) begin
        ptr_next = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
      end
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      out_valid_reg <= 1'b0;
      ptr_reg       <= '0;
    end else begin
      out_data_reg  <= out_data_next;
      out_chan_reg  <= out_chan_next;
      out_valid_reg <= out_valid_next;
      ptr_reg       <= ptr_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_chan  = out_chan_reg;
  assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr: an 8-channel x 16-bit instance for
// fixed/round-robin/back-pressure/reset behaviour and a 5-channel x 8-bit
// instance for out-of-range select codes.
module tb_stream_mux_rr;

  logic clk;
  logic reset;

  // 8 x 16 instance
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic         mode;
  logic [2:0]   sel;
  logic [15:0]  out_data;
  logic [2:0]   out_chan;
  logic         out_valid;
  logic         out_ready;

  // 5 x 8 instance
  logic [39:0]  in_data5;
  logic [4:0]   in_valid5;
  logic [4:0]   in_ready5;
  logic         mode5;
  logic [2:0]   sel5;
  logic [7:0]   out_data5;
  logic [2:0]   out_chan5;
  logic         out_valid5;
  logic         out_ready5;

  int vec_cnt;
  int miscmp_cnt;

  stream_mux_rr #(.WIDTH(16), .CHANNELS(8)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CHANNELS(5)) dut5 (
    .clk(clk), .reset(reset),
    .in_data(in_data5), .in_valid(in_valid5), .in_ready(in_ready5),
    .mode(mode5), .sel(sel5),
    .out_data(out_data5), .out_chan(out_chan5), .out_valid(out_valid5),
    .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("pass %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int rr_seq1 [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 1};
  int rr_seq2 [8]  = '{2, 4, 5, 6, 7, 0, 1, 2};

  initial begin
    vec_cnt    = 0;
    miscmp_cnt = 0;
    reset      = 1'b1;
    in_valid   = '0;
    mode       = 1'b0;
    sel        = '0;
    out_ready  = 1'b0;
    in_valid5  = '0;
    mode5      = 1'b0;
    sel5       = '0;
    out_ready5 = 1'b0;
    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = 16'h1000 + 16'(i);
    for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'h50 + 8'(i);

    // Reset state
    #1;
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_data", 32'(out_data), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b0;

    // Fixed mode, sel = 5
    step();
    mode      = 1'b0;
    sel       = 3'd5;
    in_valid  = 8'hFF;
    out_ready = 1'b1;
    #1;
    check_val("fix_in_ready0", 32'(in_ready), 32'h20);
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("fix_out_data", 32'(out_data), 32'h1005);
      check_val("fix_out_chan", 32'(out_chan), 32'd5);
      check_val("fix_out_valid", 32'(out_valid), 32'd1);
      check_val("fix_in_ready", 32'(in_ready), 32'h20);
    end

    // Round-robin, all channels valid; pointer still 0 after fixed mode
    mode = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      check_val("rr_in_ready", 32'(in_ready), 32'(1) << rr_seq1[k]);
      step();
      check_val("rr_out_chan", 32'(out_chan), 32'(rr_seq1[k]));
      check_val("rr_out_data", 32'(out_data), 32'h1000 + 32'(rr_seq1[k]));
    end

    // Channel 3 drops out; pointer now at 2
    in_valid = 8'hF7;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_val("rr_skip_in_ready", 32'(in_ready), 32'(1) << rr_seq2[k]);
      step();
      check_val("rr_skip_out_chan", 32'(out_chan), 32'(rr_seq2[k]));
    end

    // Back-pressure: last output was channel 2, pointer 3
    out_ready = 1'b0;
    #1;
    check_val("bp_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("bp_out_valid", 32'(out_valid), 32'd1);
      check_val("bp_out_chan", 32'(out_chan), 32'd2);
      check_val("bp_out_data", 32'(out_data), 32'h1002);
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_release_in_ready", 32'(in_ready), 32'h10);
    step();
    check_val("bp_reload_out_valid", 32'(out_valid), 32'd1);
    check_val("bp_reload_out_chan", 32'(out_chan), 32'd4);

    // Wrap-around: win with channel 6 to park the pointer at 7
    in_valid = 8'h40;
    #1;
    check_val("wrap_prime_in_ready", 32'(in_ready), 32'h40);
    step();
    check_val("wrap_prime_out_chan", 32'(out_chan), 32'd6);
    in_valid = 8'h42;
    #1;
    check_val("wrap_in_ready_a", 32'(in_ready), 32'h02);
    step();
    check_val("wrap_out_chan_a", 32'(out_chan), 32'd1);
    check_val("wrap_in_ready_b", 32'(in_ready), 32'h40);
    step();
    check_val("wrap_out_chan_b", 32'(out_chan), 32'd6);
    check_val("wrap_in_ready_c", 32'(in_ready), 32'h02);
    step();
    check_val("wrap_out_chan_c", 32'(out_chan), 32'd1);

    // Drain with no new input: valid drops, tag is kept
    in_valid = 8'h00;
    step();
    check_val("drain_out_valid", 32'(out_valid), 32'd0);
    check_val("drain_out_chan", 32'(out_chan), 32'd1);

    // Reload (pointer at 2), then reset mid-cycle
    in_valid = 8'hFF;
    step();
    check_val("preload_out_chan", 32'(out_chan), 32'd2);
    check_val("preload_out_valid", 32'(out_valid), 32'd1);
    #3 reset = 1'b1;
    #1;
    check_val("async_rst_out_valid", 32'(out_valid), 32'd0);
    check_val("async_rst_out_data", 32'(out_data), 32'd0);
    check_val("async_rst_out_chan", 32'(out_chan), 32'd0);
    check_val("async_rst_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b0;
    #1;
    check_val("post_rst_in_ready", 32'(in_ready), 32'h01);
    step();
    check_val("post_rst_out_chan", 32'(out_chan), 32'd0);

    // Non-power-of-two instance, out-of-range select
    mode5      = 1'b0;
    sel5       = 3'd6;
    in_valid5  = 5'h1F;
    out_ready5 = 1'b1;
    #1;
    check_val("np2_sel6_in_ready", 32'(in_ready5), 32'd0);
    step();
    check_val("np2_sel6_out_valid", 32'(out_valid5), 32'd0);
    sel5 = 3'd7;
    #1;
    check_val("np2_sel7_in_ready", 32'(in_ready5), 32'd0);
    step();
    check_val("np2_sel7_out_valid", 32'(out_valid5), 32'd0);
    sel5 = 3'd4;
    #1;
    check_val("np2_sel4_in_ready", 32'(in_ready5), 32'h10);
    step();
    check_val("np2_sel4_out_chan", 32'(out_chan5), 32'd4);
    check_val("np2_sel4_out_data", 32'(out_data5), 32'h54);
    check_val("np2_sel4_out_valid", 32'(out_valid5), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
